matcher_mem_arbiter: RTL and testbench
======================================

# matcher_mem_arbiter

- Shares the single 32-bit matcher DPRAM port among `NUM_REQ` on-chip requesters with round-robin arbitration: `o_mem_ce`, `o_mem_we`, `o_mem_addr`, `o_mem_in`, `i_mem_out`, 1-cycle read latency.
- Requesters are, for example, the matching sequencer (reset-flag read, match/pass/filter writes) and a statistics/debug reader.
- Sits between the requesters and the DPRAM port; registers the memory-side command and returns read data to the requester that issued the access.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, ≥1
- `ADDR_WIDTH`, 10: word address width
- `DATA_WIDTH`, 32: data width
- `WE_WIDTH`, 4: byte-enable width, `DATA_WIDTH/8`

Ports. Clock i_fclk; reset i_reset_n, synchronous, active-low. Per-requester buses are packed, requester k at slice k.
- `i_fclk`  in  1  clock
- `i_reset_n`  in  1  synchronous active-low reset
- `i_req`  in  NUM_REQ  access request, held until granted
- `i_lock`  in  NUM_REQ  keep grant after this beat (macro-gated)
- `i_we`  in  NUM_REQ*WE_WIDTH  byte write enables; all zero = read
- `i_addr`  in  NUM_REQ*ADDR_WIDTH  word address
- `i_wdata`  in  NUM_REQ*DATA_WIDTH  write data
- `o_gnt`  out  NUM_REQ  one-hot grant; beat accepted when `i_req[k]` and `o_gnt[k]` are both high
- `o_rvalid`  out  NUM_REQ  read data valid for requester k
- `o_rdata`  out  DATA_WIDTH  read data, shared, qualified by `o_rvalid`
- `o_mem_ce`  out  1  DPRAM chip enable
- `o_mem_we`  out  WE_WIDTH  DPRAM byte write enables
- `o_mem_addr`  out  ADDR_WIDTH  DPRAM address
- `o_mem_in`  out  DATA_WIDTH  DPRAM write data
- `i_mem_out`  in  DATA_WIDTH  DPRAM read data, valid 1 cycle after a read command

## Operation
**Grant**
- `o_gnt` is combinational from `i_req`, the priority pointer `ptr` and the state.
- At most one bit is high. No grant without a request.

**State machine**
- `ST_ARB`:
  - Grant the first requesting index at or after `ptr`, searching upward and wrapping `NUM_REQ-1` → 0.
  - On acceptance by requester k: `ptr` ← (k+1) mod `NUM_REQ`.
  - If `i_lock[k]`=1 on that beat: `owner` ← k and the state moves to `ST_LOCKED`.
- `ST_LOCKED`:
  - `o_gnt` = one-hot(`owner`) & `i_req`.
  - Return to `ST_ARB` on an accepted beat with `i_lock`=0, or on any cycle with `i_req[owner]`=0.
  - `ptr` stays at `owner`+1.

**Commands**
- An accepted beat is registered onto `o_mem_*` in the next cycle with `o_mem_ce`=1.
- On cycles with no accepted beat, `o_mem_ce`=0 and `o_mem_we`=0. `o_mem_addr` and `o_mem_in` hold their last value.

**Reads**
- A read beat (`i_we`=0) tags requester k into a 2-stage valid pipeline.
- `o_rvalid[k]` pulses for 1 cycle. `o_rdata` = `i_mem_out` (passthrough).

**Writes**
- Write beats produce no `o_rvalid`. Partial byte enables pass through unchanged.

**Boundary conditions**
- No requests: `ptr` and state are unchanged.
- All requesters active: strict rotation, one beat per cycle, 100% port utilisation.
- `NUM_REQ`=1: `o_gnt` = `i_req`.
- Back-to-back reads from different requesters: each `o_rvalid` is tagged to the correct requester, one per cycle.

## Timing
**Reset values** (while `i_reset_n`=0):
- `o_gnt`, `o_rvalid`, `o_mem_ce` and `o_mem_we` are 0; `o_gnt` is forced 0 during reset.
- `o_mem_addr` and `o_mem_in` are 0.
- `ptr` = 0, state = `ST_ARB`, read pipeline cleared.

**Latency**
- Beat accepted in cycle T → DPRAM command in T+1 → `o_rvalid`/`o_rdata` in T+2.
- Throughput: 1 beat per cycle.

**Handshake**
- A requester holds `i_we`/`i_addr`/`i_wdata`/`i_lock` stable while `i_req`=1 and ungranted.
- A requester may change them on the cycle after acceptance.

**Reset mid-operation**
- In-flight reads are discarded; no `o_rvalid` is asserted for them after reset.
- A lock in progress is dropped.

## Configuration
- `MATCHER_MEM_ARB_LOCK_EN` defined:
  - `i_lock` is honoured and `ST_LOCKED` exists.
  - Use case: the sequencer's match/pass/filter triple is written atomically with no interleaved beats.
- Not defined:
  - `i_lock` is ignored and the state stays `ST_ARB`.
  - Pure round-robin per beat; `owner` logic is not synthesised.

## Structure
**Shared package `matcher_mem_pkg`:**
- Constants `ADDR_RESET`=0x01, `ADDR_MATCH`=0x02, `ADDR_PASS`=0x03, `ADDR_FILTER`=0x04.
- Default widths (10/32/4).
- Arbiter state encoding `ST_ARB`=0, `ST_LOCKED`=1.

**Sub-module `matcher_mem_rr_pick`:**
- Combinational one-hot round-robin picker: inputs `req` and `ptr`, outputs `gnt` and encoded index.
- Instantiated once.

## Test plan
- **Reset:** assert `i_reset_n`=0 with `i_req`=2'b11 → `o_gnt`=0, `o_mem_ce`=0, `o_rvalid`=0. After release, first grant goes to req0 (`ptr`=0).
- **Rotation:** req0 and req1 both hold reads of 0x002 and 0x003 → grants alternate 01,10,01…. `o_mem_addr` alternates 0x002/0x003 one cycle after each grant. `o_rvalid` alternates two cycles after acceptance, with `o_rdata` equal to the preloaded words.
- **Write:** req1 writes 0x004, `we`=0xF, data 0xDEADBEEF → `o_mem_we`=0xF and `o_mem_in`=0xDEADBEEF in T+1, no `o_rvalid`. A subsequent read of 0x004 by req0 returns 0xDEADBEEF.
- **Lock (macro on):** req0 issues 3 writes to 0x002–0x004 with `i_lock`=1,1,0 while req1 requests continuously → req0 is granted 3 consecutive cycles, then req1. With the macro off, the grants interleave 0,1,0,1,0.
- **Lock drop:** req0 locks, then deasserts `i_req` → the arbiter returns to `ST_ARB` the same cycle and req1 is granted.
- **Reset mid-read:** reset is asserted in T+1 after a read acceptance → no `o_rvalid` pulse appears after reset.

Source files
------------

// File: rtl/matcher_mem_pkg.sv
// Shared constants and types for the matcher DPRAM arbiter slice.
package matcher_mem_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 10;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_WE_WIDTH   = 4;

    localparam logic [DEF_ADDR_WIDTH-1:0] ADDR_RESET  = 10'h001;
    localparam logic [DEF_ADDR_WIDTH-1:0] ADDR_MATCH  = 10'h002;
    localparam logic [DEF_ADDR_WIDTH-1:0] ADDR_PASS   = 10'h003;
    localparam logic [DEF_ADDR_WIDTH-1:0] ADDR_FILTER = 10'h004;

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Index width that stays legal for a single requester.
    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matcher_mem_arbiter_if.sv
// Requester-side and DPRAM-side bundle of the matcher memory arbiter.
interface matcher_mem_arbiter_if
    import matcher_mem_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned WE_WIDTH   = DATA_WIDTH / 8
) ();

    logic [NUM_REQ-1:0]            i_req;
    logic [NUM_REQ-1:0]            i_lock;
    logic [NUM_REQ*WE_WIDTH-1:0]   i_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] i_wdata;
    logic [NUM_REQ-1:0]            o_gnt;
    logic [NUM_REQ-1:0]            o_rvalid;
    logic [DATA_WIDTH-1:0]         o_rdata;
    logic                          o_mem_ce;
    logic [WE_WIDTH-1:0]           o_mem_we;
    logic [ADDR_WIDTH-1:0]         o_mem_addr;
    logic [DATA_WIDTH-1:0]         o_mem_in;
    logic [DATA_WIDTH-1:0]         i_mem_out;

    // Arbiter side.
    modport slave (
        input  i_req, i_lock, i_we, i_addr, i_wdata, i_mem_out,
        output o_gnt, o_rvalid, o_rdata, o_mem_ce, o_mem_we, o_mem_addr, o_mem_in
    );

    // Requesters plus DPRAM side.
    modport master (
        output i_req, i_lock, i_we, i_addr, i_wdata, i_mem_out,
        input  o_gnt, o_rvalid, o_rdata, o_mem_ce, o_mem_we, o_mem_addr, o_mem_in
    );

endinterface

// File: rtl/matcher_mem_rr_pick.sv
// Combinational round-robin picker: lowest requesting index at or above ptr, else lowest overall.
module matcher_mem_rr_pick
    import matcher_mem_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic [NUM_REQ-1:0] hi_mask;
    logic [NUM_REQ-1:0] pool;

    always_comb begin
        hi_mask = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            hi_mask[i] = (i >= 32'(ptr_i));
        end
        // Wrap to the bottom only when nothing at or above ptr is requesting.
        pool = (|(req_i & hi_mask)) ? (req_i & hi_mask) : req_i;
        gnt_o = '0;
        idx_o = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (pool[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
                idx_o    = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/matcher_mem_arbiter.sv
// Round-robin arbiter sharing the matcher DPRAM port; define MATCHER_MEM_ARB_LOCK_EN to honour
// i_lock (multi-beat ownership), otherwise every beat is arbitrated independently.
module matcher_mem_arbiter
    import matcher_mem_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned WE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  i_fclk,
    input  logic                  i_reset_n,
    matcher_mem_arbiter_if.slave  bus
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);

    arb_state_e                state_q, state_d;
    logic [IDX_W-1:0]          ptr_q, ptr_d;
    logic [NUM_REQ-1:0]        pick_gnt;
    logic [IDX_W-1:0]          pick_idx;
    logic [NUM_REQ-1:0]        gnt;
    logic [IDX_W-1:0]          acc_idx;
    logic                      acc;
    logic                      locked;
    logic [WE_WIDTH-1:0]       sel_we;

    logic                      mem_ce_q, mem_ce_d;
    logic [WE_WIDTH-1:0]       mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]     mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]     mem_in_q, mem_in_d;
    logic [NUM_REQ-1:0]        rd_tag_q, rd_tag_d;
    logic [NUM_REQ-1:0]        rvalid_q, rvalid_d;

    matcher_mem_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i (bus.i_req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

`ifdef MATCHER_MEM_ARB_LOCK_EN
    logic [IDX_W-1:0] owner_q, owner_d;

    // An owner that drops its request falls straight back to arbitration in the same cycle.
    assign locked = (state_q == ST_LOCKED) && bus.i_req[owner_q];
`else
    logic unused_lock;

    assign unused_lock = ^bus.i_lock;
    assign locked      = 1'b0;
`endif

    always_comb begin
        gnt     = pick_gnt;
        acc_idx = pick_idx;
`ifdef MATCHER_MEM_ARB_LOCK_EN
        if (locked) begin
            gnt          = '0;
            gnt[owner_q] = 1'b1;
            acc_idx      = owner_q;
        end
`endif
        if (!i_reset_n) begin
            gnt = '0;
        end
        acc    = |gnt;
        sel_we = bus.i_we[32'(acc_idx) * WE_WIDTH +: WE_WIDTH];
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (acc) begin
            ptr_d = (acc_idx == IDX_W'(NUM_REQ - 1)) ? '0 : acc_idx + 1'b1;
        end
`ifdef MATCHER_MEM_ARB_LOCK_EN
        owner_d = owner_q;
        if (locked) begin
            if (!bus.i_lock[owner_q]) begin
                state_d = ST_ARB;
            end
        end else begin
            state_d = ST_ARB;
            if (acc && bus.i_lock[acc_idx]) begin
                state_d = ST_LOCKED;
                owner_d = acc_idx;
            end
        end
`endif
    end

    always_comb begin
        mem_ce_d   = acc;
        mem_we_d   = '0;
        mem_addr_d = mem_addr_q;
        mem_in_d   = mem_in_q;
        if (acc) begin
            mem_we_d   = sel_we;
            mem_addr_d = bus.i_addr[32'(acc_idx) * ADDR_WIDTH +: ADDR_WIDTH];
            mem_in_d   = bus.i_wdata[32'(acc_idx) * DATA_WIDTH +: DATA_WIDTH];
        end
        rd_tag_d = (acc && (sel_we == '0)) ? gnt : '0;
        rvalid_d = rd_tag_q;
    end

    always_ff @(posedge i_fclk) begin
        if (!i_reset_n) begin
            state_q    <= ST_ARB;
            ptr_q      <= '0;
            mem_ce_q   <= 1'b0;
            mem_we_q   <= '0;
            mem_addr_q <= '0;
            mem_in_q   <= '0;
            rd_tag_q   <= '0;
            rvalid_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            mem_ce_q   <= mem_ce_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_in_q   <= mem_in_d;
            rd_tag_q   <= rd_tag_d;
            rvalid_q   <= rvalid_d;
        end
    end

`ifdef MATCHER_MEM_ARB_LOCK_EN
    always_ff @(posedge i_fclk) begin
        if (!i_reset_n) begin
            owner_q <= '0;
        end else begin
            owner_q <= owner_d;
        end
    end
`endif

    assign bus.o_gnt      = gnt;
    assign bus.o_rvalid   = rvalid_q;
    assign bus.o_rdata    = bus.i_mem_out;
    assign bus.o_mem_ce   = mem_ce_q;
    assign bus.o_mem_we   = mem_we_q;
    assign bus.o_mem_addr = mem_addr_q;
    assign bus.o_mem_in   = mem_in_q;

endmodule

// File: tb/tb_matcher_mem_arbiter.sv
// Directed-vector bench for matcher_mem_arbiter with a small DPRAM model behind the port.
module tb_matcher_mem_arbiter;

    localparam logic [31:0] R2 = 32'hA5A5_0002;
    localparam logic [31:0] R3 = 32'h5A5A_0003;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;

    typedef struct {
        logic        rst_n;
        logic [1:0]  req;
        logic [7:0]  we;
        logic [19:0] addr;
        logic [63:0] wdata;
        logic [1:0]  gnt;
        logic        ce;
        logic [3:0]  mwe;
        logic [9:0]  maddr;
        logic [31:0] min;
        logic [1:0]  rv;
        logic [31:0] rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic mem_preload;
    logic [31:0] mem [16];
    logic [31:0] mem_out_q;
    vec_t vecs [$];
    logic [1:0] lock_exp [$];
    logic [1:0] drop_exp_a;
    int n_vec = 0;
    int n_err = 0;
    int step;

    always #5 clk = ~clk;

    matcher_mem_arbiter_if #(
        .NUM_REQ    (2),
        .ADDR_WIDTH (10),
        .DATA_WIDTH (32),
        .WE_WIDTH   (4)
    ) bus ();

    matcher_mem_arbiter #(
        .NUM_REQ    (2),
        .ADDR_WIDTH (10),
        .DATA_WIDTH (32),
        .WE_WIDTH   (4)
    ) dut (
        .i_fclk    (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    // DPRAM model: one-cycle read latency, byte-enabled writes.
    always @(posedge clk) begin
        if (mem_preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'(i);
            mem[2] <= R2;
            mem[3] <= R3;
        end else if (bus.o_mem_ce) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.o_mem_we[b]) mem[bus.o_mem_addr[3:0]][b*8 +: 8] <= bus.o_mem_in[b*8 +: 8];
            end
            if (bus.o_mem_we == 4'h0) mem_out_q <= mem[bus.o_mem_addr[3:0]];
        end
    end
    assign bus.i_mem_out = mem_out_q;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic r, input logic [1:0] q, input logic [7:0] w,
                                input logic [9:0] a1, input logic [9:0] a0,
                                input logic [31:0] d1, input logic [31:0] d0,
                                input logic [1:0] g, input logic c, input logic [3:0] mw,
                                input logic [9:0] ma, input logic [31:0] mi,
                                input logic [1:0] v, input logic [31:0] rd);
        vec_t t;
        t.rst_n = r; t.req = q; t.we = w; t.addr = {a1, a0}; t.wdata = {d1, d0};
        t.gnt = g; t.ce = c; t.mwe = mw; t.maddr = ma; t.min = mi; t.rv = v; t.rdata = rd;
        vecs.push_back(t);
    endfunction

    task automatic drive(input logic [1:0] q, input logic [1:0] l, input logic [7:0] w,
                         input logic [19:0] a, input logic [63:0] d);
        bus.i_req = q; bus.i_lock = l; bus.i_we = w; bus.i_addr = a; bus.i_wdata = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //   rst req  we     a1  a0   d1  d0   gnt  ce mwe ma  min rv   rdata
        add(0, 2'b11, 8'h00, 3, 2, 0,  0,  2'b00, 0, 0, 0, 0,  2'b00, 0);
        add(1, 2'b11, 8'h00, 3, 2, 0,  0,  2'b01, 0, 0, 0, 0,  2'b00, 0);
        add(1, 2'b11, 8'h00, 3, 2, 0,  0,  2'b10, 1, 0, 2, 0,  2'b00, 0);
        add(1, 2'b11, 8'h00, 3, 2, 0,  0,  2'b01, 1, 0, 3, 0,  2'b01, R2);
        add(1, 2'b11, 8'h00, 3, 2, 0,  0,  2'b10, 1, 0, 2, 0,  2'b10, R3);
        add(1, 2'b10, 8'hF0, 4, 2, DB, 0,  2'b10, 1, 0, 3, 0,  2'b01, R2);
        add(1, 2'b01, 8'h00, 4, 4, 0,  0,  2'b01, 1, 4'hF, 4, DB, 2'b10, R3);
        add(1, 2'b00, 8'h00, 0, 0, 0,  0,  2'b00, 1, 0, 4, 0,  2'b00, 0);
        add(1, 2'b00, 8'h00, 0, 0, 0,  0,  2'b00, 0, 0, 4, 0,  2'b01, DB);
        add(1, 2'b00, 8'h00, 0, 0, 0,  0,  2'b00, 0, 0, 4, 0,  2'b00, 0);
        add(1, 2'b11, 8'h00, 3, 2, 0,  0,  2'b10, 0, 0, 4, 0,  2'b00, 0);
        add(1, 2'b00, 8'h00, 0, 0, 0,  0,  2'b00, 1, 0, 3, 0,  2'b00, 0);
        add(1, 2'b00, 8'h00, 0, 0, 0,  0,  2'b00, 0, 0, 3, 0,  2'b10, R3);

`ifdef MATCHER_MEM_ARB_LOCK_EN
        lock_exp   = '{2'b01, 2'b01, 2'b01, 2'b10};
        drop_exp_a = 2'b01;
`else
        lock_exp   = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
        drop_exp_a = 2'b10;
`endif

        rst_n = 1'b0;
        mem_preload = 1'b1;
        drive(2'b00, 2'b00, '0, '0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_preload = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n;
            drive(vecs[i].req, 2'b00, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            #1;
            n_vec++;
            chk($sformatf("v%0d_gnt", i),   64'(bus.o_gnt),      64'(vecs[i].gnt));
            chk($sformatf("v%0d_ce", i),    64'(bus.o_mem_ce),   64'(vecs[i].ce));
            chk($sformatf("v%0d_we", i),    64'(bus.o_mem_we),   64'(vecs[i].mwe));
            chk($sformatf("v%0d_addr", i),  64'(bus.o_mem_addr), 64'(vecs[i].maddr));
            chk($sformatf("v%0d_in", i),    64'(bus.o_mem_in),   64'(vecs[i].min));
            chk($sformatf("v%0d_rv", i),    64'(bus.o_rvalid),   64'(vecs[i].rv));
            if (vecs[i].rv != 2'b00) begin
                chk($sformatf("v%0d_rdata", i), 64'(bus.o_rdata), 64'(vecs[i].rdata));
            end
        end

        // req0 writes three words (lock 1,1,0) while req1 reads continuously.
        step = 0;
        for (int c = 0; c < lock_exp.size(); c++) begin
            @(negedge clk);
            if (step < 3) begin
                drive({1'b1, 1'b1}, {1'b0, step < 2}, 8'h0F, {10'd4, 10'(2 + step)},
                      {32'h0, {4{8'(step + 1)}}});
            end else begin
                drive(2'b10, 2'b00, 8'h00, {10'd4, 10'd0}, '0);
            end
            #1;
            n_vec++;
            chk($sformatf("lock_gnt%0d", c), 64'(bus.o_gnt), 64'(lock_exp[c]));
            if (bus.o_gnt[0]) step++;
        end
        @(negedge clk);
        drive(2'b00, 2'b00, '0, '0, '0);
        repeat (3) @(negedge clk);

        // Owner drops its request right after locking; the other requester gets the port.
        drive(2'b11, 2'b01, 8'h00, {10'd3, 10'd2}, '0);
        #1;
        n_vec++;
        chk("drop_gnt_a", 64'(bus.o_gnt), 64'(drop_exp_a));
        @(negedge clk);
        drive(2'b10, 2'b00, 8'h00, {10'd3, 10'd2}, '0);
        #1;
        n_vec++;
        chk("drop_gnt_b", 64'(bus.o_gnt), 64'(2'b10));
        @(negedge clk);
        drive(2'b00, 2'b00, '0, '0, '0);
        repeat (3) @(negedge clk);

        // Reset lands the cycle after a read is accepted.
        drive(2'b01, 2'b00, 8'h00, {10'd0, 10'd2}, '0);
        #1;
        n_vec++;
        chk("rst_mid_gnt", 64'(bus.o_gnt), 64'(2'b01));
        @(negedge clk);
        rst_n = 1'b0;
        drive(2'b11, 2'b00, 8'h00, {10'd3, 10'd2}, '0);
        #1;
        n_vec++;
        chk("rst_forced_gnt", 64'(bus.o_gnt), 64'(2'b00));
        @(negedge clk);
        rst_n = 1'b1;
        drive(2'b00, 2'b00, '0, '0, '0);
        #1;
        n_vec++;
        chk("rst_rv", 64'(bus.o_rvalid), 64'(2'b00));
        chk("rst_ce", 64'(bus.o_mem_ce), 64'(1'b0));
        chk("rst_addr", 64'(bus.o_mem_addr), 64'(10'd0));
        @(negedge clk);
        drive(2'b11, 2'b00, 8'h00, {10'd3, 10'd2}, '0);
        #1;
        n_vec++;
        chk("rst_rv2", 64'(bus.o_rvalid), 64'(2'b00));
        chk("rst_first_gnt", 64'(bus.o_gnt), 64'(2'b01));
        @(negedge clk);
        drive(2'b00, 2'b00, '0, '0, '0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
